// File: rtl/au_issue_ctrl.sv
// rtl/au_issue_ctrl.sv - issue/writeback sequencer and register file feeding the S9.14 AU
module au_issue_ctrl #(
  parameter int W       = 24,
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    instr_op,
  input  logic [1:0]    instr_ysel,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs,
  input  logic [AW-1:0] instr_rt,
  input  logic [W-1:0]  instr_imm,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [W-1:0]  host_wdata,
  output logic [W-1:0]  host_rdata,
  output logic          au_start,
  output logic [W-1:0]  au_R,
  output logic [W-1:0]  au_S,
  output logic [W-1:0]  au_Iimm,
  output logic [1:0]    au_op_sel,
  output logic [1:0]    au_mul_y_sel,
  input  logic [W-1:0]  au_result,
  input  logic          au_done,
  input  logic          au_busy,
  output logic          busy,
  output logic          err_timeout,
  input  logic          err_clr,
  output logic [15:0]   retire_cnt
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t          state;
  logic [W-1:0]    regs [NREG];
  logic [AW-1:0]   rd_q;
  logic [W-1:0]    res_q;
  logic [CW-1:0]   wait_cnt;

  // Ready only in IDLE and never while reset is being applied.
  assign instr_ready = (state == S_IDLE) && !rst;
  assign busy        = (state != S_IDLE);
  // Start fires in the ISSUE cycle the AU reports itself free; the FSM leaves ISSUE on that same edge.
  assign au_start    = (state == S_ISSUE) && !au_busy;

  // Sequencer: operand latch on accept, issue guard, bounded wait for done, writeback bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      au_R         <= '0;
      au_S         <= '0;
      au_Iimm      <= '0;
      au_op_sel    <= '0;
      au_mul_y_sel <= '0;
      rd_q         <= '0;
      res_q        <= '0;
      wait_cnt     <= '0;
      err_timeout  <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      // A timeout set later in this block overrides a simultaneous clear.
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            au_R         <= regs[instr_rs];
            au_S         <= regs[instr_rt];
            au_Iimm      <= instr_imm;
            au_op_sel    <= instr_op;
            au_mul_y_sel <= instr_ysel;
            rd_q         <= instr_rd;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!au_busy) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (au_done) begin
            // Negative zero is folded to +0 before it reaches the register file.
            res_q <= (au_result[W-2:0] == '0) ? '0 : au_result;
            state <= S_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          retire_cnt <= retire_cnt + 16'd1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file: host write first so a same-address writeback lands last; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (host_we && (host_addr != '0)) regs[host_addr] <= host_wdata;
      if ((state == S_WB) && (rd_q != '0)) regs[rd_q] <= res_q;
    end
  end

  // Host readback with one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) host_rdata <= '0;
    else     host_rdata <= regs[host_addr];
  end

endmodule

// File: tb/tb_au_issue_ctrl.sv
// tb/tb_au_issue_ctrl.sv - randomized self-checking bench for au_issue_ctrl with an AU stub
module tb_au_issue_ctrl;

  localparam int W = 24;
  localparam int AW = 4;
  localparam int NREG = 16;
  localparam int TIMEOUT = 64;

  logic          clk;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [1:0]    instr_ysel;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs;
  logic [AW-1:0] instr_rt;
  logic [W-1:0]  instr_imm;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_wdata;
  logic [W-1:0]  host_rdata;
  logic          au_start;
  logic [W-1:0]  au_R;
  logic [W-1:0]  au_S;
  logic [W-1:0]  au_Iimm;
  logic [1:0]    au_op_sel;
  logic [1:0]    au_mul_y_sel;
  logic [W-1:0]  au_result;
  logic          au_done;
  logic          au_busy;
  logic          busy;
  logic          err_timeout;
  logic          err_clr;
  logic [15:0]   retire_cnt;

  au_issue_ctrl #(.W(W), .NREG(NREG), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_ysel(instr_ysel),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_imm(instr_imm),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .au_start(au_start), .au_R(au_R), .au_S(au_S), .au_Iimm(au_Iimm),
    .au_op_sel(au_op_sel), .au_mul_y_sel(au_mul_y_sel),
    .au_result(au_result), .au_done(au_done), .au_busy(au_busy),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference state
  logic [W-1:0] mregs [NREG];
  int mretire = 0;
  bit merr = 0;

  // AU stub controls
  int stub_lat = 0;
  bit stub_never = 0;
  bit stub_force = 0;
  logic [W-1:0] stub_force_val = '0;
  logic [W-1:0] stub_res = '0;
  int cd = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint sm_val(input logic [W-1:0] x);
    longint m;
    m = longint'(x[W-2:0]);
    return x[W-1] ? -m : m;
  endfunction

  function automatic logic [W-1:0] sm_pack(input longint v);
    longint m;
    m = (v < 0) ? -v : v;
    if (m > 64'h7FFFFF) m = 64'h7FFFFF;
    return {(v < 0) ? 1'b1 : 1'b0, m[W-2:0]};
  endfunction

  // Behavioural AU: sign-magnitude S9.14 arithmetic.
  function automatic logic [W-1:0] au_model(input int op, input int ysel, input logic [W-1:0] r,
                                            input logic [W-1:0] s, input logic [W-1:0] imm);
    longint m;
    logic [W-1:0] y;
    case (op)
      0: return sm_pack(sm_val(r) + sm_val(s));
      1: return sm_pack(sm_val(r) - sm_val(s));
      2: begin
        y = (ysel == 0) ? s : imm;
        m = (longint'(r[W-2:0]) * longint'(y[W-2:0])) >>> 14;
        return sm_pack((r[W-1] ^ y[W-1]) ? -m : m);
      end
      default: return sm_pack(sm_val(r) + sm_val(imm));
    endcase
  endfunction

  function automatic logic [W-1:0] norm(input logic [W-1:0] x);
    return (x[W-2:0] == '0) ? '0 : x;
  endfunction

  // AU stub: reacts to start mid-cycle, pulses done in WAIT cycle stub_lat+1.
  initial begin
    au_done = 1'b0;
    au_result = '0;
    forever begin
      @(negedge clk);
      if (cd == 0) begin
        au_done = 1'b1;
        au_result = stub_res;
        cd = -1;
      end else begin
        au_done = 1'b0;
        if (cd > 0) cd--;
      end
      if (au_start) begin
        stub_res = stub_force ? stub_force_val
                              : au_model(int'(au_op_sel), int'(au_mul_y_sel), au_R, au_S, au_Iimm);
        if (!stub_never) cd = stub_lat;
      end
    end
  end

  task automatic hwrite(input int a, input logic [W-1:0] d);
    host_we = 1'b1;
    host_addr = AW'(a);
    host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
    if (a != 0) mregs[a] = d;
  endtask

  task automatic hread(input int a, input logic [W-1:0] exp);
    host_addr = AW'(a);
    @(posedge clk); #2;
    check($sformatf("host_rdata r%0d", a), 32'(host_rdata), 32'(exp));
  endtask

  task automatic run_instr(input int op, input int ysel, input int rd, input int rs, input int rt,
                           input logic [W-1:0] imm, input int lat, input int hold, input bit never,
                           input bit hw_en, input int hw_idx, input int hw_addr,
                           input logic [W-1:0] hw_data);
    int n;
    int k;
    int cycles;
    int starts;
    int exp_cycles;
    bit ops_ok;
    bit busy_ok;
    logic [W-1:0] er;
    logic [W-1:0] es;
    logic [W-1:0] exp_res;
    n = 0;
    while (!instr_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("ready_before_accept", 32'(instr_ready), 32'd1);
    er = mregs[rs];
    es = mregs[rt];
    exp_res = norm(stub_force ? stub_force_val : au_model(op, ysel, er, es, imm));
    stub_lat = lat;
    stub_never = never;
    instr_valid = 1'b1;
    instr_op = 2'(op);
    instr_ysel = 2'(ysel);
    instr_rd = AW'(rd);
    instr_rs = AW'(rs);
    instr_rt = AW'(rt);
    instr_imm = imm;
    au_busy = 1'b0;
    host_we = hw_en && (hw_idx == -1);
    host_addr = AW'(hw_addr);
    host_wdata = hw_data;
    if (hw_en && hw_idx == -1 && hw_addr != 0) mregs[hw_addr] = hw_data;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    k = 0; cycles = 0; starts = 0; ops_ok = 1; busy_ok = 1;
    while (k < 300) begin
      au_busy = (k < hold);
      host_we = hw_en && (hw_idx == k);
      #1;
      if (instr_ready) break;
      cycles++;
      if (au_start) starts++;
      if (busy !== 1'b1) busy_ok = 0;
      if ({au_R, au_S, au_Iimm, au_op_sel, au_mul_y_sel} !== {er, es, imm, 2'(op), 2'(ysel)}) ops_ok = 0;
      @(posedge clk); #1;
      k++;
    end
    au_busy = 1'b0;
    host_we = 1'b0;
    #1;
    if (hw_en && hw_idx >= 0 && hw_addr != 0) mregs[hw_addr] = hw_data;
    if (never) merr = 1;
    else begin
      if (rd != 0) mregs[rd] = exp_res;
      mretire++;
    end
    exp_cycles = never ? (1 + hold + TIMEOUT) : (3 + hold + lat);
    check("busy_cycles", 32'(cycles), 32'(exp_cycles));
    check("start_pulses", 32'(starts), 32'd1);
    check("operands_stable", 32'(ops_ok), 32'd1);
    check("busy_while_active", 32'(busy_ok), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("retire_cnt", 32'(retire_cnt), 32'(mretire[15:0]));
    check("err_timeout", 32'(err_timeout), 32'(merr));
    stub_never = 0;
    hread(rd, mregs[rd]);
    if (hw_en) hread(hw_addr, mregs[hw_addr]);
  endtask

  initial begin
    int op, rd, rs, rt, lat, hold, hwi, hwa;
    bit hwe;
    rst = 1'b1;
    instr_valid = 1'b0; instr_op = '0; instr_ysel = '0;
    instr_rd = '0; instr_rs = '0; instr_rt = '0; instr_imm = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    au_busy = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < NREG; i++) mregs[i] = '0;

    repeat (2) @(posedge clk); #1;
    check("ready_in_reset", 32'(instr_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_retire", 32'(retire_cnt), 32'd0);
    check("reset_err", 32'(err_timeout), 32'd0);
    check("reset_au_R", 32'(au_R), 32'd0);
    check("reset_au_start", 32'(au_start), 32'd0);
    check("reset_rdata", 32'(host_rdata), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(instr_ready), 32'd1);

    hwrite(1, 24'h008000);
    hwrite(2, 24'h80C000);
    hwrite(0, 24'h123456);
    hread(0, 24'h000000);

    run_instr(0, 0, 3, 1, 2, 24'h0, 2, 0, 0, 0, 0, 0, 0);
    hread(3, 24'h804000);
    run_instr(2, 0, 4, 1, 2, 24'h0, 3, 0, 0, 0, 0, 0, 0);
    hread(4, 24'h818000);

    stub_force = 1; stub_force_val = 24'h800000;
    run_instr(1, 0, 5, 1, 1, 24'h0, 1, 0, 0, 0, 0, 0, 0);
    hread(5, 24'h000000);
    stub_force = 0;
    run_instr(0, 0, 0, 1, 2, 24'h0, 0, 0, 0, 0, 0, 0, 0);
    hread(0, 24'h000000);
    check("retire_after_r0", 32'(retire_cnt), 32'd4);

    hwrite(7, 24'h001234);
    err_clr = 1'b1;
    run_instr(0, 0, 7, 1, 2, 24'h0, 0, 0, 1, 0, 0, 0, 0);
    err_clr = 1'b0;
    hread(7, 24'h001234);
    check("retire_after_timeout", 32'(retire_cnt), 32'd4);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    merr = 0;
    check("err_cleared", 32'(err_timeout), 32'd0);

    stub_force = 1; stub_force_val = 24'h004000;
    run_instr(0, 0, 6, 1, 2, 24'h0, 1, 0, 0, 1, 3, 6, 24'h00C000);
    hread(6, 24'h004000);
    stub_force = 0;
    run_instr(0, 0, 8, 1, 2, 24'h0, 1, 5, 0, 0, 0, 0, 0);
    run_instr(0, 0, 9, 1, 2, 24'h0, 0, 0, 0, 1, -1, 1, 24'h7FFFFF);

    for (int i = 1; i < NREG; i++) hwrite(i, 24'($urandom) & 24'h83FFFF);
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 3));
      rd = int'($urandom_range(0, 15));
      rs = int'($urandom_range(0, 15));
      rt = int'($urandom_range(0, 15));
      lat = int'($urandom_range(0, 4));
      hold = int'($urandom_range(0, 3));
      hwe = ($urandom_range(0, 1) == 1);
      hwi = int'($urandom_range(0, hold + lat + 3)) - 1;
      hwa = (t % 5 == 0) ? rd : int'($urandom_range(0, 15));
      run_instr(op, int'($urandom_range(0, 3)), rd, rs, rt, 24'($urandom) & 24'h83FFFF,
                lat, hold, 0, hwe, hwi, hwa, 24'($urandom) & 24'h83FFFF);
    end

    // reset while the AU is working; its done arrives two cycles after the reset edge
    stub_lat = 3;
    instr_valid = 1'b1; instr_op = 2'd0; instr_rd = 4'd9; instr_rs = 4'd1; instr_rt = 4'd2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    mretire = 0;
    repeat (4) @(posedge clk);
    #2;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    check("post_rst_retire", 32'(retire_cnt), 32'd0);
    check("post_rst_au_R", 32'(au_R), 32'd0);
    for (int i = 0; i < NREG; i++) hread(i, mregs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/au_issue_ctrl.md
Name: au_issue_ctrl

Overview:
Issue/writeback controller that sits directly upstream of the AU (arithmetic unit, S9.14 sign-magnitude, start/done/busy handshake).
- Accepts one micro-instruction at a time over a valid/ready port.
- Reads both operands from a local NREG x W register file.
- Drives the AU operand and control inputs and pulses AU start.
- Waits for AU done, then writes the result back into the register file.
- A host port preloads and reads back registers. Together, the register file and sequencing feed the AU for the Kalman update datapath.

Parameters:
W, 24, datapath width; S9.14 sign-magnitude (bit W-1 = sign).
NREG, 16, register file depth.
AW, 4, register address width (log2 NREG).
TIMEOUT, 64, maximum WAIT cycles before abort.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
instr_valid  in  1  instruction present.
instr_ready  out  1  controller can accept an instruction.
instr_op  in  2  AU op: 00 ADD, 01 SUB, 10 MULT, 11 multi-cycle op.
instr_ysel  in  2  passed through to AU mul_y_sel.
instr_rd  in  AW  destination register.
instr_rs  in  AW  source register driving AU R_in.
instr_rt  in  AW  source register driving AU S_in.
instr_imm  in  W  immediate driving AU Iimm_in.
host_we  in  1  host register write enable.
host_addr  in  AW  host write/read address.
host_wdata  in  W  host write data.
host_rdata  out  W  registered read of regfile[host_addr], 1-cycle latency.
au_start  out  1  one-cycle start pulse to AU.
au_R  out  W  operand R.
au_S  out  W  operand S.
au_Iimm  out  W  immediate.
au_op_sel  out  2  AU op select.
au_mul_y_sel  out  2  AU Y select.
au_result  in  W  AU result.
au_done  in  1  AU result valid.
au_busy  in  1  AU busy; used for the issue guard only.
busy  out  1  high in any state other than IDLE.
err_timeout  out  1  sticky timeout flag.
err_clr  in  1  clears err_timeout.
retire_cnt  out  16  count of written-back instructions; wraps modulo 2^16.

Behaviour:
Reset (rst=1 at an edge, regardless of state):
- FSM goes to IDLE; all regfile entries, au_* outputs, host_rdata, err_timeout and retire_cnt go to 0.
- instr_ready is 0 during any cycle with rst=1.
- An in-flight AU operation is abandoned and its late au_done is ignored.

FSM states IDLE, ISSUE, WAIT, WB:
- IDLE: instr_ready=1.
  - On instr_valid & instr_ready: latch op, ysel, rd and imm; latch regfile[rs] into au_R and regfile[rt] into au_S (pre-edge values); go to ISSUE.
- ISSUE: if au_busy=0, assert au_start for exactly this cycle and go to WAIT. Otherwise hold ISSUE with au_start=0.
- WAIT: au_done is sampled only in this state.
  - On au_done=1: capture au_result, go to WB.
  - A timeout counter increments each WAIT cycle. After TIMEOUT cycles without done: set err_timeout, perform no writeback, leave retire_cnt unchanged, go to IDLE.
- WB: write regfile[rd], increment retire_cnt, go to IDLE.

Operand and latency rules:
- au_R, au_S, au_Iimm, au_op_sel and au_mul_y_sel stay stable from ISSUE through WAIT.
- Minimum latency from accept edge to writeback edge is 3 cycles plus AU latency.
- Back-to-back throughput is one instruction per (4 + AU latency) cycles.
- No hazard logic is needed: the next accept always follows WB.

Register file rules:
- r0 always reads +0; writes to r0 from WB or host are discarded.
- -0 normalisation: if the captured result has magnitude 0, +0 (all zeros) is written.
- Host write in the same cycle as WB to the same address: WB data wins. Different addresses: both writes occur.
- A host write in the accept cycle does not affect the operands latched that cycle.
- host_we is honoured in every state.

err_timeout:
- Stays set until err_clr=1 or rst.
- If a set condition and err_clr occur in the same cycle, set wins.

Test Plan:
- Preload r1=0x008000 (2.0), r2=0x80C000 (-3.0); ADD rd=3 rs=1 rt=2 -> au_start is a single pulse; r3=0x804000 (-1.0); retire_cnt=1; instr_ready low from accept through WB.
- MULT rd=4 rs=1 rt=2, ysel=00 -> r4=0x818000 (-6.0); au_R/au_S stay stable from ISSUE until done.
- AU stub returns 0x800000 for SUB r5=r1-r1 -> r5 reads 0x000000. ADD with rd=0 -> r0 stays 0, retire_cnt still increments.
- AU stub never asserts done -> exactly 64 WAIT cycles, then err_timeout=1, rd unchanged, retire_cnt unchanged, instr_ready=1. err_clr -> flag returns to 0.
- Host write r6=0x00C000 in the same cycle as WB to r6 carrying 0x004000 -> r6=0x004000. au_busy=1 held 5 cycles in ISSUE -> au_start delayed until au_busy falls.
- Assert rst during WAIT, then the stub asserts done 2 cycles later -> no writeback, regfile all 0, FSM in IDLE, retire_cnt=0.
